timer_tc: RTL and testbench

TIMER_TC -- requirements
Module: timer_tc

---
 rtl/timer_tc.sv | 154 +++++++++++++++
 tb/tb_timer_tc.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tc.sv
// -----------------------------------------------------------------------------
// timer_tc -- memory-mapped down-counting timer with interrupt.
//
// Register map (word offset = Addr[3:2]):
//   0  CTRL    [3] IM (interrupt mask), [2:1] MODE (01 auto-reload, else
//              one-shot), [0] EN. Reads back as {28'b0, CTRL}.
//   1  PRESET  32-bit reload value, read/write.
//   2  COUNT   32-bit current count, read-only.
//   3  unmapped, reads 0, writes ignored.
//
// Ports:
//   clk    in   1   single clock, rising edge
//   reset  in   1   synchronous active-low reset
//   Addr   in  30   word address [31:2]; only [3:2] decoded
//   WE     in   1   write strobe (already qualified by block select)
//   Din    in  32   write data
//   Dout   out 32   read data, combinational from Addr[3:2]
//   IRQ    out  1   interrupt request = IM & irq_flag
// -----------------------------------------------------------------------------
module timer_tc (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_PRESET = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO  = 2'b01;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        en;
    logic [1:0]  mode;
    logic        wr_ctrl;
    logic        wr_preset;

    // Block select is done by the bridge; the upper address bits carry no
    // information here.
    logic        unused_addr;
    assign unused_addr = ^Addr[31:4];

    assign en        = ctrl_q[0];
    assign mode      = ctrl_q[2:1];
    assign wr_ctrl   = WE && (Addr[3:2] == OFS_CTRL);
    assign wr_preset = WE && (Addr[3:2] == OFS_PRESET);

    // -------------------------------------------------------------------------
    // Next-state logic: FSM action first, then CPU writes layered on top so a
    // CTRL write in the INT cycle overrides the automatic EN clear.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a
        // path that skips an assignment infers a latch.
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // PRESET of 0 or 1 both expire here; never wrap below 0.
                    count_d    = 32'd0;
                    state_d    = S_INT;
                    irq_flag_d = 1'b1;
                end
            end
            S_INT: begin
                if (mode == MODE_AUTO) begin
                    state_d    = S_LOAD;
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_ctrl) begin
            ctrl_d     = Din[3:0];
            irq_flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d   = Din;
            irq_flag_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers; reset has priority over any write in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read mux and interrupt output
    // -------------------------------------------------------------------------
    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            OFS_CTRL:   Dout = {28'd0, ctrl_q};
            OFS_PRESET: Dout = preset_q;
            OFS_COUNT:  Dout = count_q;
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = ctrl_q[3] & irq_flag_q;

endmodule

// File: tb/tb_timer_tc.sv
// -----------------------------------------------------------------------------
// tb_timer_tc -- self-checking bench for timer_tc: register-access vector
// table, hand-written multi-cycle sequences, and a randomized run against a
// behavioural model.
// -----------------------------------------------------------------------------
module tb_timer_tc;

    logic        clk;
    logic        rst_n;
    logic [31:2] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    timer_tc dut (
        .clk   (clk),
        .reset (rst_n),
        .Addr  (addr),
        .WE    (we),
        .Din   (din),
        .Dout  (dout),
        .IRQ   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [1:0] a);
        addr = {28'($urandom), a};
    endtask

    // One write, committed at the next rising edge.
    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        set_addr(a);
        we  = 1'b1;
        din = d;
        tick();
        we  = 1'b0;
    endtask

    task automatic check_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        set_addr(a);
        #1;
        check(name, dout, exp);
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // --------------------------------------------------------- behavioural model
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;

    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    longint      m_count;
    bit          m_flag;
    int          m_ph;

    // Applies the timer's rules for one rising edge given the inputs sampled
    // at that edge.
    task automatic model_edge(input bit rst_v, input bit we_v, input logic [1:0] a,
                              input logic [31:0] d);
        logic [3:0]  c;
        logic [31:0] p;
        longint      n;
        bit          f;
        int          ph;
        if (!rst_v) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 0; m_flag = 1'b0; m_ph = PH_IDLE;
            return;
        end
        c = m_ctrl; p = m_preset; n = m_count; f = m_flag; ph = m_ph;
        if (m_ph == PH_IDLE && m_ctrl[0]) ph = PH_LOAD;
        if (m_ph == PH_LOAD) begin
            n  = longint'(m_preset);
            ph = PH_CNT;
        end
        if (m_ph == PH_CNT) begin
            if (!m_ctrl[0])      ph = PH_IDLE;
            else if (m_count > 1) n = m_count - 1;
            else begin
                n = 0; ph = PH_INT; f = 1'b1;
            end
        end
        if (m_ph == PH_INT) begin
            if (m_ctrl[2:1] == 2'b01) begin
                ph = PH_LOAD; f = 1'b0;
            end else begin
                c[0] = 1'b0; ph = PH_IDLE;
            end
        end
        if (we_v && a == 2'd0) begin c = d[3:0]; f = 1'b0; end
        if (we_v && a == 2'd1) begin p = d;      f = 1'b0; end
        m_ctrl = c; m_preset = p; m_count = n; m_flag = f; m_ph = ph;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return 32'(m_count);
            default: return 32'd0;
        endcase
    endfunction

    // --------------------------------------------------------- register vectors
    typedef struct {
        logic [1:0]  wa;
        logic        wr;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp_d;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'd1, 1'b1, 32'h1234_5678, 2'd1, 32'h1234_5678, 1'b0};
        vecs[1] = '{2'd0, 1'b1, 32'hFFFF_FFF0, 2'd0, 32'h0000_0000, 1'b0};
        vecs[2] = '{2'd2, 1'b1, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000, 1'b0};
        vecs[3] = '{2'd3, 1'b1, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000, 1'b0};
        vecs[4] = '{2'd1, 1'b0, 32'hDEAD_BEEF, 2'd1, 32'h1234_5678, 1'b0};
        vecs[5] = '{2'd0, 1'b1, 32'hFFFF_FFF6, 2'd0, 32'h0000_0006, 1'b0};
        vecs[6] = '{2'd1, 1'b1, 32'h0000_0000, 2'd1, 32'h0000_0000, 1'b0};
        vecs[7] = '{2'd0, 1'b1, 32'hFFFF_FFFF, 2'd0, 32'h0000_000F, 1'b0};
    end

    // ------------------------------------------------------------------- main
    initial begin
        rst_n = 1'b0; we = 1'b0; din = 32'd0; addr = '0;
        #1;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        for (int a = 0; a < 4; a++) check_rd($sformatf("reset_rd%0d", a), 2'(a), 32'd0);
        check_irq("reset_irq", 1'b0);

        // Register access table (FSM idle until the last entry sets EN)
        foreach (vecs[i]) begin
            set_addr(vecs[i].wa);
            we  = vecs[i].wr;
            din = vecs[i].wd;
            tick();
            we = 1'b0;
            check_rd($sformatf("vec%0d_rd", i), vecs[i].ra, vecs[i].exp_d);
            check_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end

        // One-shot count: PRESET=3, CTRL=0x9
        do_reset();
        do_write(2'd1, 32'd3);
        do_write(2'd0, 32'h9);                            // E0
        tick(); check_rd("os_e1_count", 2'd2, 32'd0);     // LOAD
        tick(); check_rd("os_e2_count", 2'd2, 32'd3);
        tick(); check_rd("os_e3_count", 2'd2, 32'd2);
        tick(); check_rd("os_e4_count", 2'd2, 32'd1); check_irq("os_e4_irq", 1'b0);
        tick(); check_rd("os_e5_count", 2'd2, 32'd0); check_irq("os_e5_irq", 1'b1);
        tick(); check_rd("os_e6_ctrl", 2'd0, 32'h8);  check_irq("os_e6_irq", 1'b1);
        tick(); tick();
        check_irq("os_hold_irq", 1'b1);
        check_rd("os_hold_count", 2'd2, 32'd0);
        do_write(2'd0, 32'h8);
        check_irq("os_clear_irq", 1'b0);

        // Auto-reload: PRESET=2, CTRL=0xB -> IRQ pulse every 4 cycles
        do_reset();
        do_write(2'd1, 32'd2);
        do_write(2'd0, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            logic [31:0] exp_cnt;
            tick();
            case ((k - 2) % 4)
                0:       exp_cnt = 32'd2;
                1:       exp_cnt = 32'd1;
                default: exp_cnt = 32'd0;
            endcase
            if (k == 1) exp_cnt = 32'd0;
            check_irq($sformatf("ar_irq_k%0d", k), (k >= 4) && (k % 4 == 0));
            check_rd($sformatf("ar_cnt_k%0d", k), 2'd2, exp_cnt);
        end

        // Masked interrupt: PRESET=1, CTRL=0x1
        do_reset();
        do_write(2'd1, 32'd1);
        do_write(2'd0, 32'h1);
        tick(); tick(); tick();                           // E3: INT
        check_irq("mask_int_irq", 1'b0);
        tick();
        check_rd("mask_en_cleared", 2'd0, 32'h0);
        do_write(2'd0, 32'h8);
        check_irq("mask_unmask_irq", 1'b0);

        // PRESET=0 behaves as 1
        do_reset();
        do_write(2'd1, 32'd0);
        do_write(2'd0, 32'h9);
        tick(); tick();
        check_irq("p0_e2_irq", 1'b0);
        tick();
        check_irq("p0_e3_irq", 1'b1);

        // Disable mid-count, then reset with a simultaneous write
        do_reset();
        do_write(2'd1, 32'd10);
        do_write(2'd0, 32'h1);
        repeat (5) tick();                                // E5: COUNT=7
        check_rd("dis_e5_count", 2'd2, 32'd7);
        do_write(2'd0, 32'h0);                            // E6: last decrement
        check_rd("dis_e6_count", 2'd2, 32'd6);
        repeat (3) tick();
        check_rd("dis_frozen_count", 2'd2, 32'd6);
        rst_n = 1'b0;
        set_addr(2'd1); we = 1'b1; din = 32'hABCD_0123;
        tick();
        rst_n = 1'b1; we = 1'b0;
        for (int a = 0; a < 4; a++) check_rd($sformatf("rst_rd%0d", a), 2'(a), 32'd0);
        check_irq("rst_irq", 1'b0);

        // Collision: CTRL write in INT (MODE=00) beats the automatic EN clear
        do_reset();
        do_write(2'd1, 32'd2);
        do_write(2'd0, 32'h1);
        repeat (4) tick();                                // E4: INT
        check_rd("col_int_count", 2'd2, 32'd0);
        do_write(2'd0, 32'h1);                            // E5: IDLE, EN kept
        check_rd("col_ctrl", 2'd0, 32'h1);
        tick(); check_rd("col_load_count", 2'd2, 32'd0);
        tick(); check_rd("col_restart_count", 2'd2, 32'd2);
        tick(); check_rd("col_dec_count", 2'd2, 32'd1);

        // Randomized run against the model
        do_reset();
        model_edge(1'b0, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 500; i++) begin
            bit          r_rst, r_we;
            logic [1:0]  r_a, r_ra;
            logic [31:0] r_d;
            r_rst = ($urandom_range(0, 79) != 0);
            r_we  = ($urandom_range(0, 5) == 0);
            r_a   = 2'($urandom_range(0, 3));
            r_d   = (r_a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
            rst_n = r_rst;
            we    = r_we;
            din   = r_d;
            set_addr(r_a);
            @(posedge clk);
            model_edge(r_rst, r_we, r_a, r_d);
            #1;
            rst_n = 1'b1;
            we    = 1'b0;
            r_ra  = 2'($urandom_range(0, 3));
            set_addr(r_ra);
            #1;
            check($sformatf("rnd%0d_rd%0d", i, r_ra), dout, model_read(r_ra));
            check_irq($sformatf("rnd%0d_irq", i), m_ctrl[3] & m_flag);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
